bit_serial_add_ctrl: RTL
========================

BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be legal for 1..32.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 in_valid_i  input  1  operand set offered.
REQ-005 in_ready_o  output  1  block accepts an operand set.
REQ-006 a_i  input  WIDTH  operand A.
REQ-007 b_i  input  WIDTH  operand B.
REQ-008 cin_i  input  1  carry-in.
REQ-009 out_valid_o  output  1  result available.
REQ-010 out_ready_i  input  1  consumer takes the result.
REQ-011 sum_o  output  WIDTH  sum bits.
REQ-012 cout_o  output  1  final carry.
REQ-013 busy_o  output  1  high in RUN or DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; the block SHALL process one operand set at a time, with no overlap.
REQ-015 IDLE: in_ready_o=1; input handshake (in_valid_i & in_ready_o) at an edge SHALL latch a_i, b_i, cin_i into shift and carry registers, clear the bit counter and move to RUN.
REQ-016 RUN: in_ready_o=0; each edge SHALL add one bit pair, LSB first, through a single full-adder cell; the sum bit SHALL shift into the result register MSB-down and the carry register SHALL update.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide; after WIDTH RUN edges the FSM SHALL move to DONE.
REQ-018 Latency: out_valid_o SHALL rise exactly WIDTH edges after the input-handshake edge.
REQ-019 DONE: out_valid_o=1; sum_o and cout_o SHALL hold stable until out_ready_i=1 at an edge, then the FSM SHALL move to IDLE.
REQ-020 Result: {cout_o,sum_o} SHALL equal a+b+cin as a (WIDTH+1)-bit value; no overflow is lost.
REQ-021 in_valid_i in RUN or DONE SHALL be ignored; operands SHALL not be sampled.
REQ-022 Toggling a_i/b_i/cin_i after acceptance SHALL NOT affect the result.
REQ-023 out_ready_i outside DONE SHALL be ignored.
REQ-024 Throughput: one result per WIDTH+2 cycles minimum (accept, WIDTH RUN edges, DONE handshake, IDLE).
REQ-025 out_valid_o, busy_o and in_ready_o SHALL be registered-state decodes with no combinational path from inputs.

Reset
REQ-026 rst_i=1 at an edge SHALL force IDLE from any state, including mid-RUN and DONE with a pending result, and discard the operation.
REQ-027 Post-reset values: in_ready_o=1, out_valid_o=0, busy_o=0, sum_o=0, cout_o=0, counter=0, carry=0.
REQ-028 rst_i SHALL take priority over any simultaneous handshake.

Structure
REQ-029 Shared package bit_serial_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-030 One sub-module, full_adder, built from two half_adder instances plus an OR gate, SHALL be the only arithmetic cell.
REQ-031 Target size: 120-400 lines of RTL.

Verification
REQ-032 WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> after 8 edges sum_o=8'h00, cout_o=1, out_valid_o=1.
REQ-033 WIDTH=8, a=0, b=0, cin=1 -> sum_o=8'h01, cout_o=0; a=8'hA5, b=8'h5A, cin=1 -> sum_o=8'h00, cout_o=1.
REQ-034 Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0; out_ready_i=1 -> IDLE next cycle.
REQ-035 Reset at RUN edge 4 -> next cycle in_ready_o=1, out_valid_o=0, sum_o=0; new operation 3+4 -> sum_o=8'h07.
REQ-036 in_valid_i held high with changing operands during RUN -> only the first set is used; WIDTH=1 build: 1+1+1 -> sum_o=1, cout_o=1 after 1 edge.
REQ-037 Random test of 1000 operand sets against a+b+cin, with random out_ready_i stalls -> no mismatch.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: controller states and default width.
package bit_serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder composed of two half adders and an OR for the carry.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (
      .a   (a),
      .b   (b),
      .sum (s1),
      .cout(c1)
   );

   half_adder u_ha1 (
      .a   (s1),
      .b   (cin),
      .sum (sum),
      .cout(c2)
   );

   assign cout = c1 | c2;

endmodule

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b;
   assign cout = a & b;

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder: accepts one operand set, adds it LSB first over WIDTH cycles
// through a single full adder, then holds {cout,sum} until the consumer takes it.
module bit_serial_add_ctrl
   import bit_serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             busy_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [WIDTH-1:0] res_next;
   logic             carry_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             fa_sum;
   logic             fa_cout;

   full_adder u_fa (
      .a   (a_reg[0]),
      .b   (b_reg[0]),
      .cin (carry_reg),
      .sum (fa_sum),
      .cout(fa_cout)
   );

   // Each new sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at LSB.
   always_comb begin
      res_next            = res_reg >> 1;
      res_next[WIDTH-1]   = fa_sum;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid_i) begin
                  a_reg     <= a_i;
                  b_reg     <= b_i;
                  carry_reg <= cin_i;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               a_reg     <= a_reg >> 1;
               b_reg     <= b_reg >> 1;
               res_reg   <= res_next;
               carry_reg <= fa_cout;
               cnt_reg   <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_BIT) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (state_reg == IDLE);
   assign out_valid_o = (state_reg == DONE);
   assign busy_o      = (state_reg != IDLE);
   assign sum_o       = res_reg;
   assign cout_o      = carry_reg;

endmodule
